// File: rtl/nibble_add_seq.sv
// Sequential WIDTH-bit adder: one 4-bit carry-lookahead slice reused per nibble,
// LSB nibble first, with the inter-nibble carry held in a register.

module nibble_add_seq_ha (
  input  logic x,
  input  logic y,
  output logic p,
  output logic g
);
  assign p = x ^ y;
  assign g = x & y;
endmodule

module nibble_add_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int N  = WIDTH / 4;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [KW-1:0]    k;
  logic [WIDTH-1:0] a_r, b_r;
  logic             cy;

  logic [3:0] a_k, b_k, p, g, sn;
  logic [4:0] c;

  assign a_k = a_r[{k, 2'b00} +: 4];
  assign b_k = b_r[{k, 2'b00} +: 4];

  nibble_add_seq_ha u_ha [3:0] (.x(a_k), .y(b_k), .p(p), .g(g));

  // Fully expanded lookahead: every carry depends only on p/g and the slice carry-in.
  assign c[0] = cy;
  assign c[1] = g[0] | (p[0] & cy);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cy);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cy);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cy);
  assign sn   = p ^ c[3:0];

  assign in_ready  = (state == S_IDLE) && !rst;
  assign out_valid = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      k     <= '0;
      cy    <= 1'b0;
      a_r   <= '0;
      b_r   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (in_valid) begin
          a_r   <= a;
          b_r   <= b;
          cy    <= cin;
          k     <= '0;
          state <= S_RUN;
        end
        S_RUN: begin
          sum[{k, 2'b00} +: 4] <= sn;
          cy <= c[4];
          k  <= k + 1'b1;
          if (k == K_LAST) begin
            cout  <= c[4];
            ovf   <= c[3] ^ c[4];
            state <= S_DONE;
          end
        end
        S_DONE: if (out_ready) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_nibble_add_seq.sv
// Bench for nibble_add_seq: directed cases on a 16-bit instance, then random
// regression on 4/16/32-bit instances against plain a+b+cin arithmetic.

module tb_nibble_add_seq;
  localparam int NOPS = 1000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec, n_err;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // directed 16-bit instance
  logic        rst_d, d_iv, d_ir, d_cin, d_ov, d_or, d_co, d_of;
  logic [15:0] d_a, d_b, d_sum;

  nibble_add_seq #(.WIDTH(16)) u_dut (
    .clk(clk), .rst(rst_d), .in_valid(d_iv), .in_ready(d_ir), .a(d_a), .b(d_b), .cin(d_cin),
    .out_valid(d_ov), .out_ready(d_or), .sum(d_sum), .cout(d_co), .ovf(d_of));

  // random instances
  logic       rst_r;
  logic [2:0] r_go;

  for (genvar gi = 0; gi < 3; gi++) begin : g_rnd
    localparam int W  = (gi == 0) ? 4 : (gi == 1) ? 16 : 32;
    localparam int NC = W / 4;
    logic         iv, ir, ic, ov, orr, co, of, done;
    logic [W-1:0] ia, ib, s;

    nibble_add_seq #(.WIDTH(W)) u_dut (
      .clk(clk), .rst(rst_r), .in_valid(iv), .in_ready(ir), .a(ia), .b(ib), .cin(ic),
      .out_valid(ov), .out_ready(orr), .sum(s), .cout(co), .ovf(of));

    initial begin
      logic [W-1:0] ra, rb;
      logic         rc, eo;
      logic [W:0]   e;
      int           cyc;
      string        tg;
      tg = $sformatf("w%0d", W);
      iv = 1'b0; ia = '0; ib = '0; ic = 1'b0; orr = 1'b0; done = 1'b0;
      wait (r_go[gi]);
      for (int n = 0; n < NOPS; n++) begin
        ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
        e  = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
        eo = (ra[W-1] == rb[W-1]) && (e[W-1] != ra[W-1]);
        iv = 1'b1; ia = ra; ib = rb; ic = rc;
        cyc = 0;
        while (!ir && cyc < 50) begin @(posedge clk); #1; cyc++; end
        @(posedge clk); #1;
        iv = 1'b0; ia = W'($urandom); ib = W'($urandom); ic = 1'($urandom);
        cyc = 0;
        while (!ov && cyc < NC + 5) begin @(posedge clk); #1; cyc++; end
        chk({tg, "_lat"},  64'(cyc), 64'(NC));
        chk({tg, "_sum"},  64'(s),   64'(e[W-1:0]));
        chk({tg, "_cout"}, 64'(co),  64'(e[W]));
        chk({tg, "_ovf"},  64'(of),  64'(eo));
        do begin
          orr = ($urandom_range(0, 3) != 0);
          @(posedge clk); #1;
          if (!orr) begin
            chk({tg, "_stall_ov"},  64'(ov), 64'(1));
            chk({tg, "_stall_sum"}, 64'(s),  64'(e[W-1:0]));
          end
        end while (!orr);
        orr = 1'b0;
      end
      done = 1'b1;
    end
  end

  task automatic run_op(input string tag, input logic [15:0] ta, input logic [15:0] tb_v,
                        input logic tc, input logic [15:0] es, input logic ec, input logic eo,
                        input int stall);
    int cyc;
    d_iv = 1'b1; d_a = ta; d_b = tb_v; d_cin = tc; d_or = 1'b0;
    cyc = 0;
    while (!d_ir && cyc < 50) begin @(posedge clk); #1; cyc++; end
    @(posedge clk); #1;
    // scramble operands while RUN is in progress
    d_iv = 1'b0; d_a = 16'hFFFF; d_b = 16'hFFFF; d_cin = 1'b1;
    cyc = 0;
    while (!d_ov && cyc < 20) begin @(posedge clk); #1; cyc++; end
    chk({tag, "_lat"},  64'(cyc + 1), 64'(5));
    chk({tag, "_sum"},  64'(d_sum), 64'(es));
    chk({tag, "_cout"}, 64'(d_co),  64'(ec));
    chk({tag, "_ovf"},  64'(d_of),  64'(eo));
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      chk({tag, "_bp_ov"},  64'(d_ov),  64'(1));
      chk({tag, "_bp_sum"}, 64'(d_sum), 64'(es));
      chk({tag, "_bp_co"},  64'({d_co, d_of}), 64'({ec, eo}));
      chk({tag, "_bp_ir"},  64'(d_ir),  64'(0));
    end
    d_or = 1'b1;
    @(posedge clk); #1;
    d_or = 1'b0;
    chk({tag, "_idle_ov"}, 64'(d_ov), 64'(0));
    chk({tag, "_idle_ir"}, 64'(d_ir), 64'(1));
  endtask

  initial begin
    int first, second, cyc;
    logic seen;
    n_vec = 0; n_err = 0;
    rst_d = 1'b1; rst_r = 1'b1; r_go = '0;
    d_iv = 1'b0; d_a = '0; d_b = '0; d_cin = 1'b0; d_or = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ir",   64'(d_ir),  64'(0));
    chk("rst_ov",   64'(d_ov),  64'(0));
    chk("rst_sum",  64'(d_sum), 64'(0));
    chk("rst_flag", 64'({d_co, d_of}), 64'(0));
    rst_d = 1'b0; rst_r = 1'b0;
    #1;
    chk("rst_rel_ir", 64'(d_ir), 64'(1));

    run_op("wrap",  16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 0);
    run_op("sovf1", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 0);
    run_op("sovf2", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1);
    run_op("cin",   16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0, 3);

    // back-to-back with in_valid and out_ready held high
    d_a = 16'h1111; d_b = 16'h2222; d_cin = 1'b0; d_iv = 1'b1; d_or = 1'b1;
    first = -1; second = -1;
    for (int c = 0; c < 30 && second < 0; c++) begin
      if (d_ir) begin
        if (first < 0) first = c; else second = c;
      end
      if (d_ov) chk("b2b_sum", 64'(d_sum), 64'h3333);
      @(posedge clk); #1;
    end
    d_iv = 1'b0;
    chk("b2b_space", 64'(second - first), 64'(6));
    cyc = 0;
    while (!d_ov && cyc < 20) begin @(posedge clk); #1; cyc++; end
    chk("b2b_sum2", 64'(d_sum), 64'h3333);
    @(posedge clk); #1;
    d_or = 1'b0;

    // reset coinciding with a handshake wins
    d_iv = 1'b1; d_a = 16'h0101; d_b = 16'h0202; rst_d = 1'b1;
    @(posedge clk); #1;
    rst_d = 1'b0; d_iv = 1'b0; d_or = 1'b1;
    seen = 1'b0;
    repeat (8) begin @(posedge clk); #1; seen |= d_ov; end
    chk("rst_hs_noout", 64'(seen), 64'(0));
    d_or = 1'b0;

    // reset in the 2nd RUN cycle
    d_iv = 1'b1; d_a = 16'h0F0F; d_b = 16'h00F1; d_cin = 1'b0;
    @(posedge clk); #1;
    d_iv = 1'b0;
    @(posedge clk); #1;
    rst_d = 1'b1;
    @(posedge clk); #1;
    chk("mid_ov",  64'(d_ov),  64'(0));
    chk("mid_sum", 64'(d_sum), 64'(0));
    chk("mid_ir",  64'(d_ir),  64'(0));
    rst_d = 1'b0;
    #1;
    chk("mid_idle", 64'(d_ir), 64'(1));
    d_or = 1'b1;
    seen = 1'b0;
    repeat (10) begin @(posedge clk); #1; seen |= d_ov; end
    chk("mid_noout", 64'(seen), 64'(0));
    run_op("post", 16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0, 0);

    r_go[0] = 1'b1; wait (g_rnd[0].done);
    r_go[1] = 1'b1; wait (g_rnd[1].done);
    r_go[2] = 1'b1; wait (g_rnd[2].done);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
